// File: rtl/cache_pkg.sv
// Shared constants, controller state encoding and address-field helpers for the
// direct-mapped read-only cache.
package cache_pkg;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, UPDATE, RESPOND} state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:INDEX_W+OFFSET_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[INDEX_W+OFFSET_W-1:OFFSET_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction
endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid store: one entry per line, async read, single write port; only the
// valid bits are cleared by reset.
module cache_tag_store #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag
);
  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst)       valid_q <= '0;
    else if (wr_en) valid_q[wr_index] <= 1'b1;
  end

  // Stale tags are harmless once their valid bit is clear, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_index] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache sequencer: hit/miss decision, word-by-word line fill from
// main memory, and saturating hit/miss statistics.
module cache_controller import cache_pkg::*; #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [ADDR_W-1:0]           req_addr,
  output logic                        done,
  output logic                        hit,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        line_wr,
  output logic [INDEX_W+OFFSET_W-1:0] line_addr,
  output logic [DATA_W-1:0]           line_wdata,
  output logic [CNT_W-1:0]            hit_count,
  output logic [CNT_W-1:0]            miss_count
);
  localparam int TW = ADDR_W - INDEX_W - OFFSET_W;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [OFFSET_W-1:0]  cnt_q, cnt_d;
  logic                 hit_r_q, hit_r_d;
  logic                 done_q, hit_q;
  logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q;

  logic [TW-1:0]        tag;
  logic [INDEX_W-1:0]   idx;
  logic                 st_valid;
  logic [TW-1:0]        st_tag;
  logic                 tag_we;

  assign tag = addr_tag(addr_q);
  assign idx = addr_index(addr_q);

  cache_tag_store #(.INDEX_W(INDEX_W), .TAG_W(TW)) u_tags (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx),
    .rd_valid (st_valid),
    .rd_tag   (st_tag),
    .wr_en    (tag_we),
    .wr_index (idx),
    .wr_tag   (tag)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    hit_r_d    = hit_r_q;
    tag_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    line_wr    = 1'b0;
    line_addr  = '0;
    line_wdata = '0;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        state_d = LOOKUP;
      end
      LOOKUP: if (st_valid && st_tag == tag) begin
        hit_r_d = 1'b1;
        state_d = RESPOND;
      end else begin
        cnt_d   = '0;
        state_d = FILL;
      end
      // Data array write is a direct function of the ack so no extra cycle is spent per word.
      FILL: begin
        mem_rd   = 1'b1;
        mem_addr = {tag, idx, cnt_q};
        if (mem_ack) begin
          line_wr    = 1'b1;
          line_addr  = {idx, cnt_q};
          line_wdata = mem_rdata;
          cnt_d      = cnt_q + OFFSET_W'(1);
          if (&cnt_q) state_d = UPDATE;
        end
      end
      UPDATE: begin
        tag_we  = 1'b1;
        hit_r_d = 1'b0;
        state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      hit_r_q    <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hit_r_q <= hit_r_d;
      done_q  <= (state_q == RESPOND);
      hit_q   <= (state_q == RESPOND) && hit_r_q;
      if (state_q == RESPOND) begin
        if (hit_r_q && !(&hit_cnt_q))     hit_cnt_q  <= hit_cnt_q + 1'b1;
        if (!hit_r_q && !(&miss_cnt_q))   miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign done       = done_q;
  assign hit        = hit_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus queues expected fetches and
// completions, a negedge monitor pops and compares them as the DUT produces them.
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [14:0] req_addr = '0;
  logic        done, hit, mem_rd, line_wr;
  logic [14:0] mem_addr;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        mem_ack;
  logic [31:0] mem_rdata = '0;
  logic [9:0]  line_addr;
  logic [31:0] line_wdata;
  logic [15:0] hit_count, miss_count;

  assign mem_ack = resp_ack | stray_ack;

  cache_controller dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .done(done), .hit(hit), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .line_wr(line_wr),
    .line_addr(line_addr), .line_wdata(line_wdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit h; int hc; int mc; } done_t;

  logic [14:0] exp_mem[$];
  done_t       exp_done[$];
  int checks = 0, errors = 0;
  int acks_seen = 0;
  int ack_dly = 2;
  int exp_hc = 0, exp_mc = 0;

  function automatic logic [31:0] mdata(input logic [14:0] a);
    return {a, 2'b10, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic void chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Memory responder: ack arrives ack_dly cycles after each word is requested.
  int wait_cnt = 0;
  initial forever begin
    tick();
    if (mem_rd) begin
      if (wait_cnt == ack_dly) begin
        resp_ack  = 1'b1;
        mem_rdata = mdata(mem_addr);
        wait_cnt  = 0;
      end else begin
        resp_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor
  logic [14:0] ea;
  done_t       ed;
  always @(negedge clk) begin
    if (mem_rd && mem_ack) begin
      acks_seen++;
      if (exp_mem.size() == 0) begin
        chk("unexpected_fetch_addr", int'(mem_addr), -1);
      end else begin
        ea = exp_mem.pop_front();
        chk("mem_addr", int'(mem_addr), int'(ea));
        chk("line_wr", int'(line_wr), 1);
        chk("line_addr", int'(line_addr), int'(ea[9:0]));
        chk("line_wdata", int'(line_wdata), int'(mdata(ea)));
      end
    end else if (line_wr) begin
      chk("spurious_line_wr", int'(line_wr), 0);
    end
    if (stray_ack) chk("stray_ack_line_wr", int'(line_wr), 0);
    if (done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        ed = exp_done.pop_front();
        chk("hit", int'(hit), int'(ed.h));
        chk("hit_count", int'(hit_count), ed.hc);
        chk("miss_count", int'(miss_count), ed.mc);
      end
    end else if (hit) begin
      chk("hit_without_done", int'(hit), 0);
    end
  end

  task automatic do_req(input logic [14:0] a, input bit h);
    int lat;
    done_t e;
    if (h) exp_hc++; else exp_mc++;
    e.h = h; e.hc = exp_hc; e.mc = exp_mc;
    exp_done.push_back(e);
    if (!h) for (int w = 0; w < 4; w++) exp_mem.push_back({a[14:2], w[1:0]});
    req_valid = 1'b1;
    req_addr  = a;
    lat = -1;
    do begin tick(); lat++; end while (!done && lat < 300);
    if (!done) chk("done_timeout", lat, -1);
    else chk(h ? "hit_latency" : "miss_latency", lat, h ? 2 : 7 + 4 * ack_dly);
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = 1'b0; stray_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b1; exp_hc = 0; exp_mc = 0;
    tick();
  endtask

  initial begin
    int base, n;
    logic [14:0] a;
    tick();
    chk("rst_done", int'(done), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_line_wr", int'(line_wr), 0);
    chk("rst_line_addr", int'(line_addr), 0);
    chk("rst_line_wdata", int'(line_wdata), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_miss_count", int'(miss_count), 0);
    do_reset();

    // Cold miss, back-to-back hit, conflict eviction and refetch.
    ack_dly = 2;
    do_req(15'd1024, 1'b0);
    do_req(15'd1027, 1'b1);
    do_req(15'd2048, 1'b0);
    do_req(15'd1024, 1'b0);
    req_valid = 1'b0;
    tick();

    // Stray acks in IDLE and across a hit lookup.
    stray_ack = 1'b1;
    repeat (2) tick();
    do_req(15'd1024, 1'b1);
    stray_ack = 1'b0;
    req_valid = 1'b0;
    repeat (2) tick();

    // Reset after the second word of a fill.
    exp_mem.push_back(15'd4096);
    exp_mem.push_back(15'd4097);
    base = acks_seen;
    req_valid = 1'b1;
    req_addr  = 15'd4096;
    n = 0;
    while (acks_seen < base + 2 && n < 200) begin tick(); n++; end
    chk("midfill_acks", acks_seen - base, 2);
    rst = 1'b0; req_valid = 1'b0;
    tick();
    chk("midfill_mem_rd", int'(mem_rd), 0);
    chk("midfill_done", int'(done), 0);
    chk("midfill_hit_count", int'(hit_count), 0);
    chk("midfill_miss_count", int'(miss_count), 0);
    rst = 1'b1; exp_hc = 0; exp_mc = 0;
    repeat (3) tick();
    do_req(15'd4096, 1'b0);
    req_valid = 1'b0;
    tick();

    // Sequential sweep with slow memory.
    do_reset();
    ack_dly = 3;
    for (int i = 1024; i < 9024; i++) begin
      a = i[14:0];
      do_req(a, a[1:0] != 2'b00);
      if (errors > 50) break;
    end
    chk("sweep_hit_count", int'(hit_count), 6000);
    chk("sweep_miss_count", int'(miss_count), 2000);
    req_valid = 1'b0;
    repeat (5) tick();

    chk("pending_fetches", exp_mem.size(), 0);
    chk("pending_dones", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the direct-mapped cache. It owns the tag/valid store, decides hit or miss for each processor request, and on a miss fetches the whole line word-by-word from main memory into the cache data array. It sits between the requester (address plus done/hit handshake) and the main-memory read port, and drives the write port of the cache data array.

## Interface
Parameters:
- ADDR_W, 15, word address width (32K-word main memory)
- DATA_W, 32, word width
- INDEX_W, 8, line index width (256 lines)
- OFFSET_W, 2, word-in-line width (4 words per line)
- CNT_W, 16, hit/miss counter width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  request present; held high with stable req_addr until done
- req_addr  in  ADDR_W  requested word address
- done  out  1  one-cycle pulse; request complete
- hit  out  1  valid with done: 1 = hit, 0 = miss serviced
- mem_rd  out  1  main-memory read request
- mem_addr  out  ADDR_W  main-memory word address
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DATA_W  main-memory read data
- line_wr  out  1  cache data-array write strobe
- line_addr  out  INDEX_W+OFFSET_W  cache data-array word address {index, word}
- line_wdata  out  DATA_W  cache data-array write data
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

## Operation
- Address split: tag = req_addr[ADDR_W-1:INDEX_W+OFFSET_W] (5 bits), index = [INDEX_W+OFFSET_W-1:OFFSET_W], word = [OFFSET_W-1:0].
- States: IDLE, LOOKUP, FILL, UPDATE, RESPOND.
- IDLE: if req_valid, register req_addr, go to LOOKUP.
- LOOKUP: compare registered tag with tag_store[index] and valid[index]. Hit: go to RESPOND with hit_r=1. Miss: reset word counter to 0, go to FILL.
- FILL: mem_rd=1, mem_addr={tag, index, word_cnt}. The word is captured on a cycle with mem_rd && mem_ack: line_wr=1, line_addr={index, word_cnt}, line_wdata=mem_rdata. word_cnt then increments. Capturing word 3 goes to UPDATE. mem_ack while mem_rd=0 is ignored.
- UPDATE: tag_store[index]=tag, valid[index]=1, hit_r=0, go to RESPOND. A conflicting line is overwritten silently; there is no write-back because the cache is read-only.
- RESPOND: done=1, hit=hit_r, increment hit_count or miss_count (saturate at all-ones), go to IDLE.
- Back-to-back: if req_valid is high in IDLE the cycle after done, it is a new request. The requester changes req_addr in the same cycle it observes done.
- Reset (rst=0 on a clock edge, any state including mid-FILL): state=IDLE, all valid bits cleared, counters=0. Partially filled line stays invalid.

## Timing
- Reset values: done=0, hit=0, mem_rd=0, mem_addr=0, line_wr=0, line_addr=0, line_wdata=0, hit_count=0, miss_count=0.
- Hit latency: req_valid sampled at edge 0; done high during cycle 2 (3 cycles request-to-request).
- Miss latency: 2 + 4×(ack delay + 1) + 1 cycles to done. With same-cycle ack it is 2 + 4 + 1 = 7.
- mem_rd stays continuously high for all 4 words of a fill and drops the cycle after the 4th ack.
- mem_addr is stable while mem_rd=1 and no ack has arrived.
- line_wr is high only in ack cycles and is combinational from mem_ack within FILL.
- done and hit are registered and high for exactly one cycle.

## Structure
- Package cache_pkg: ADDR_W/INDEX_W/OFFSET_W/TAG_W constants, state enum, and address-field extract functions. These are shared with the cache data array and top-level Total.
- One sub-module, cache_tag_store: 256×(TAG_W+1) array with synchronous-reset clear of the valid bits, an asynchronous read port and one write port.

## Test plan
- Cold miss: reset, req 1024 (tag 1, index 0, word 0), mem_ack 2 cycles after each mem_rd word → mem_addr 1024, 1025, 1026, 1027; four line_wr to line_addr 0–3; done with hit=0; miss_count=1.
- Hit after fill: then req 1027 → done exactly 2 cycles after acceptance, hit=1, no mem_rd; hit_count=1.
- Conflict eviction: req 2048 (tag 2, index 0) → miss, fetch 2048–2051. Then req 1024 → miss again; miss_count=3.
- Reset mid-fill: assert rst after the 2nd ack of a fill → mem_rd=0 next cycle, no done. Re-request the same address → full miss, 4 reads.
- Sequential sweep 1024..9023, each address advanced on done, ack delay 3 → miss_count=2000, hit_count=6000, no spurious done.
- Stray mem_ack in IDLE and LOOKUP → no line_wr, state unaffected.
